// File: rtl/pack_arb_pkg.sv
// Shared definitions for the byte-packing arbiter.
//   state_t        : arbiter FSM states (PAD is used only by the flush build)
//   BYTES_PER_WORD : bytes packed into one FIFO word
//   idx_w()        : index width for a vector of n sources (minimum 1 bit)
package pack_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2,
    ST_PAD     = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pack_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after i_ptr, wrapping at N.
//   i_req  in  N    request vector
//   i_ptr  in  IW   highest-priority index this round (must be < N)
//   o_idx  out IW   picked index (0 when nothing requests)
//   o_any  out 1    at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;

  always_comb begin
    // Rotate so bit 0 corresponds to the pointer position.
    w_rot = N'({i_req, i_req} >> i_ptr);
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/pack_arbiter.sv
// Arbitrates NUM_REQ byte sources onto one 8->32 packing shift register.
// Grants one source round-robin, holds the grant for a full word, strobes
// bytes into the packer, then pushes the finished word into the FIFO.
// Optional macro TIMEOUT_FLUSH_EN: a partial word idle for TIMEOUT cycles is
// zero-padded (PAD state) and pushed with word_bytes = bytes actually received.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_data    per-source byte and valid (source i at [8i+7:8i])
//   req_ready             byte of source i accepted when valid & ready
//   shift_en/shift_data   packer shift strobe and byte
//   fifo_full             downstream FIFO cannot accept
//   fifo_push             completed word written to FIFO this edge
//   word_src/word_bytes   owner and valid byte count of the pushed word
//   busy                  FSM not idle
module pack_arbiter
  import pack_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 shift_en,
  output logic [7:0]           shift_data,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [2:0]           word_src,
  output logic [2:0]           word_bytes,
  output logic                 busy
);

  localparam int IW = idx_w(NUM_REQ);

  state_t        r_state, w_next;
  logic [1:0]    r_cnt;
  logic [IW-1:0] r_ptr, r_grant;
  logic [IW-1:0] w_pick_idx, w_ptr_inc;
  logic          w_pick_any, w_accept, w_push, w_timeout;
  logic [7:0]    w_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign w_byte[i] = req_data[8*i +: 8];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_accept  = (r_state == ST_COLLECT) && req_valid[r_grant];
  assign w_push    = (r_state == ST_PUSH) && !fifo_full;
  assign w_ptr_inc = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

`ifdef TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;
  logic [2:0]    r_bytes;

  // Fires on the TIMEOUT-th consecutive idle cycle of a partial word.
  assign w_timeout  = (r_state == ST_COLLECT) && (r_cnt != 2'd0) && !w_accept &&
                      (r_idle == TW'(TIMEOUT - 1));
  assign word_bytes = r_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle  <= '0;
      r_bytes <= 3'(BYTES_PER_WORD);
    end else begin
      if (r_state != ST_COLLECT || w_accept) r_idle <= '0;
      else if (r_cnt != 2'd0)                r_idle <= r_idle + 1'b1;
      if (w_timeout)   r_bytes <= {1'b0, r_cnt};
      else if (w_push) r_bytes <= 3'(BYTES_PER_WORD);
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign word_bytes = 3'(BYTES_PER_WORD);
`endif

  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    shift_en   = 1'b0;
    shift_data = 8'h00;
    fifo_push  = 1'b0;
    word_src   = 3'd0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        req_ready[r_grant] = 1'b1;
        shift_en           = req_valid[r_grant];
        shift_data         = w_byte[r_grant];
        if (w_accept && r_cnt == 2'(BYTES_PER_WORD - 1)) w_next = ST_PUSH;
        else if (w_timeout)                              w_next = ST_PAD;
      end
      ST_PUSH: begin
        fifo_push = !fifo_full;
        word_src  = 3'(r_grant);
        if (!fifo_full) w_next = ST_IDLE;
      end
`ifdef TIMEOUT_FLUSH_EN
      ST_PAD: begin
        // Zero bytes fill the rest of the word; sources are held off.
        shift_en = 1'b1;
        if (r_cnt == 2'(BYTES_PER_WORD - 1)) w_next = ST_PUSH;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_pick_any) r_grant <= w_pick_idx;
      // Count wraps 3->0 on the last byte of the word.
      if (w_accept || r_state == ST_PAD)    r_cnt   <= r_cnt + 1'b1;
      if (w_push)                           r_ptr   <= w_ptr_inc;
    end
  end

endmodule

// File: tb/tb_pack_arbiter.sv
module tb_pack_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        shift_en;
  logic [7:0]  shift_data;
  logic        fifo_full;
  logic        fifo_push;
  logic [2:0]  word_src;
  logic [2:0]  word_bytes;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pack_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .word_src   (word_src),
    .word_bytes (word_bytes),
    .busy       (busy)
  );

  typedef struct {
    logic        rst;
    logic        chk;
    logic [3:0]  v;
    logic [31:0] d;
    logic        full;
    logic [3:0]  e_rdy;
    logic        e_sh;
    logic [7:0]  e_sd;
    logic        e_push;
    logic [2:0]  e_src;
    logic [2:0]  e_bytes;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D2 = 32'hA3A2A1A0;

  task automatic add(input logic r, input logic c, input logic [3:0] v, input logic [31:0] d,
                     input logic full, input logic [3:0] rdy, input logic sh, input logic [7:0] sd,
                     input logic push, input logic [2:0] src, input logic [2:0] bytes,
                     input logic bsy);
    vec_t x;
    x.rst = r; x.chk = c; x.v = v; x.d = d; x.full = full;
    x.e_rdy = rdy; x.e_sh = sh; x.e_sd = sd; x.e_push = push;
    x.e_src = src; x.e_bytes = bytes; x.e_busy = bsy;
    tbl.push_back(x);
  endtask

  task automatic add_rst();
    add(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4, 1'b0);
  endtask

  task automatic add_idle(input logic [3:0] v, input logic [31:0] d);
    add(1'b0, 1'b1, v, d, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4, 1'b0);
  endtask

  task automatic add_col(input logic [3:0] v, input logic [31:0] d, input logic [3:0] rdy,
                         input logic sh, input logic [7:0] sd);
    add(1'b0, 1'b1, v, d, 1'b0, rdy, sh, sd, 1'b0, 3'd0, 3'd4, 1'b1);
  endtask

  task automatic add_push(input logic [3:0] v, input logic [31:0] d, input logic [2:0] src);
    add(1'b0, 1'b1, v, d, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, src, 3'd4, 1'b1);
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic full);
    @(negedge clk);
    rst = r; req_valid = v; req_data = d; fifo_full = full;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    logic [20:0] act, exp;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;

    // Reset state, then a single word from source 0.
    add_rst();
    add_idle(4'h0, 32'h0);
    add_idle(4'h1, 32'h11);
    add_col(4'h1, 32'h11, 4'h1, 1'b1, 8'h11);
    add_col(4'h1, 32'h22, 4'h1, 1'b1, 8'h22);
    add_col(4'h1, 32'h33, 4'h1, 1'b1, 8'h33);
    add_col(4'h1, 32'h44, 4'h1, 1'b1, 8'h44);
    add_push(4'h0, 32'h0, 3'd0);
    add_idle(4'h0, 32'h0);

    // All sources valid: grants 0,1,2,3,0.
    add_rst();
    for (int w = 0; w < 5; w++) begin
      add_idle(4'hF, D2);
      for (int b = 0; b < 4; b++)
        add_col(4'hF, D2, 4'(1 << (w % 4)), 1'b1, 8'hA0 + 8'(w % 4));
      add_push(4'hF, D2, 3'(w % 4));
    end

    // Source 1 keeps the grant while source 0 becomes valid; a stall cycle too.
    add_rst();
    add_idle(4'h2, D2);
    add_col(4'h2, D2, 4'h2, 1'b1, 8'hA1);
    add_col(4'h1, D2, 4'h2, 1'b0, 8'hA1);
    add_col(4'h3, D2, 4'h2, 1'b1, 8'hA1);
    add_col(4'h3, D2, 4'h2, 1'b1, 8'hA1);
    add_col(4'h3, D2, 4'h2, 1'b1, 8'hA1);
    add_push(4'h3, D2, 3'd1);
    // Pointer now 2; sources 2 and 3 idle, so source 0 wins.
    add_idle(4'h1, D2);
    add_col(4'h1, D2, 4'h1, 1'b1, 8'hA0);
    add_rst();
    // Pointer 0 vs source 2 valid with 0: source 0 first, then pointer 1 picks 2.
    add_idle(4'h5, D2);
    for (int b = 0; b < 4; b++) add_col(4'h5, D2, 4'h1, 1'b1, 8'hA0);
    add_push(4'h5, D2, 3'd0);
    add_idle(4'h5, D2);
    add_col(4'h5, D2, 4'h4, 1'b1, 8'hA2);

    // Reset after 2 of 4 bytes discards the word and the pointer.
    add_rst();
    add_idle(4'h4, D2);
    for (int b = 0; b < 4; b++) add_col(4'h4, D2, 4'h4, 1'b1, 8'hA2);
    add_push(4'h4, D2, 3'd2);
    add_idle(4'h8, D2);
    add_col(4'h8, D2, 4'h8, 1'b1, 8'hA3);
    add_col(4'h8, D2, 4'h8, 1'b1, 8'hA3);
    add_rst();
    add_idle(4'h9, D2);
    for (int b = 0; b < 4; b++) add_col(4'h9, D2, 4'h1, 1'b1, 8'hA0);
    add_push(4'h9, D2, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].full);
      if (tbl[i].chk) begin
        checks++;
        act = {req_ready, shift_en, shift_data, fifo_push, word_src, word_bytes, busy};
        exp = {tbl[i].e_rdy, tbl[i].e_sh, tbl[i].e_sd, tbl[i].e_push,
               tbl[i].e_src, tbl[i].e_bytes, tbl[i].e_busy};
        if (act !== exp) begin
          errors++;
          $display("FAIL vec%0d rdy/sh/sd/push/src/bytes/busy actual=%b/%b/%h/%b/%0d/%0d/%b required=%b/%b/%h/%b/%0d/%0d/%b",
                   i, req_ready, shift_en, shift_data, fifo_push, word_src, word_bytes, busy,
                   tbl[i].e_rdy, tbl[i].e_sh, tbl[i].e_sd, tbl[i].e_push,
                   tbl[i].e_src, tbl[i].e_bytes, tbl[i].e_busy);
        end
      end
    end

    // FIFO full when the word completes, held for 10 cycles.
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'h1, 32'h11, 1'b1);
    chk("full_idle_busy", 32'(busy), 32'd0);
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 4'h1, 32'h11 * (b + 1), 1'b1);
      chk("full_collect_shift", {shift_en, shift_data}, {1'b1, 8'(8'h11 * (b + 1))});
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'h1, 32'h55, 1'b1);
      chk("full_hold", {fifo_push, req_ready, shift_en, busy}, {1'b0, 4'h0, 1'b0, 1'b1});
    end
    step(1'b0, 4'h1, 32'h55, 1'b0);
    chk("full_release_push", {fifo_push, word_src, word_bytes}, {1'b1, 3'd0, 3'd4});
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("full_after_idle", {busy, fifo_push}, 2'b00);

`ifdef TIMEOUT_FLUSH_EN
    // Partial word AA,BB then silence: flush after 16 idle cycles.
    step(1'b1, 4'h0, 32'h0, 1'b0);
    step(1'b0, 4'h1, 32'hAA, 1'b0);
    step(1'b0, 4'h1, 32'hAA, 1'b0);
    chk("flush_byte_aa", {shift_en, shift_data}, {1'b1, 8'hAA});
    step(1'b0, 4'h1, 32'hBB, 1'b0);
    chk("flush_byte_bb", {shift_en, shift_data}, {1'b1, 8'hBB});
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 4'h0, 32'h0, 1'b0);
      chk("flush_wait", {shift_en, busy, fifo_push}, 3'b010);
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 4'h1, 32'hCC, 1'b0);
      chk("flush_pad", {shift_en, shift_data, req_ready}, {1'b1, 8'h00, 4'h0});
    end
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("flush_push", {fifo_push, word_src, word_bytes}, {1'b1, 3'd0, 3'd2});
    step(1'b0, 4'h0, 32'h0, 1'b0);
    chk("flush_after", {busy, word_bytes}, {1'b0, 3'd4});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
